// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and ASCII constants for the UART command parser.
// Covers the character classes, command codes and parser states.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_R = 3'd0,
        CMD_W = 3'd1,
        CMD_A = 3'd2,
        CMD_S = 3'd3,
        CMD_T = 3'd6
    } cmd_e;

    typedef enum logic [2:0] {
        CLS_DIGIT,
        CLS_CMD,
        CLS_TERM,
        CLS_SPACE,
        CLS_OTHER
    } chr_class_e;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_e;

    localparam logic [6:0] ASCII_0    = 7'h30;
    localparam logic [6:0] ASCII_9    = 7'h39;
    localparam logic [6:0] ASCII_LC_A = 7'h61;
    localparam logic [6:0] ASCII_LC_F = 7'h66;
    localparam logic [6:0] ASCII_A    = 7'h41;
    localparam logic [6:0] ASCII_E    = 7'h45;
    localparam logic [6:0] ASCII_R    = 7'h52;
    localparam logic [6:0] ASCII_S    = 7'h53;
    localparam logic [6:0] ASCII_T    = 7'h54;
    localparam logic [6:0] ASCII_W    = 7'h57;
    localparam logic [6:0] ASCII_SP   = 7'h20;
    localparam logic [6:0] ASCII_CR   = 7'h0D;
    localparam logic [6:0] ASCII_LF   = 7'h0A;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Output word channel of the command parser: valid/ack handshake plus
// the decoded command word.
interface uart_cmd_parser_if #(
    parameter int MAX_DIG = 8
);
    localparam int DATA_W = 4 * MAX_DIG;
    localparam int NDIG_W = $clog2(MAX_DIG + 1);

    logic              o_stb;
    logic              i_ack;
    logic [2:0]        o_cmd;
    logic [DATA_W-1:0] o_arg;
    logic [NDIG_W-1:0] o_ndig;
    logic              o_ovf;

    modport master (output o_stb, o_cmd, o_arg, o_ndig, o_ovf, input i_ack);
    modport slave  (input o_stb, o_cmd, o_arg, o_ndig, o_ovf, output i_ack);

endinterface

// File: rtl/uart_cmd_parser_classify.sv
// Combinational classifier for one 7-bit ASCII character: class,
// hex nibble value and command code.
module uart_ascii_classify
    import uart_cmd_pkg::*;
(
    input  logic [6:0]  chr,
    input  logic        term_on_nl,
    output chr_class_e  cls,
    output logic [3:0]  nibble,
    output logic [2:0]  cmd
);

    // Only lower-case hex letters are digits; upper-case letters are commands/terminator.
    always_comb begin
        cls    = CLS_OTHER;
        nibble = 4'h0;
        cmd    = CMD_R;
        if (chr >= ASCII_0 && chr <= ASCII_9) begin
            cls    = CLS_DIGIT;
            nibble = 4'(chr - ASCII_0);
        end else if (chr >= ASCII_LC_A && chr <= ASCII_LC_F) begin
            cls    = CLS_DIGIT;
            nibble = 4'(chr - ASCII_LC_A) + 4'd10;
        end else begin
            case (chr)
                ASCII_R: begin cls = CLS_CMD; cmd = CMD_R; end
                ASCII_W: begin cls = CLS_CMD; cmd = CMD_W; end
                ASCII_A: begin cls = CLS_CMD; cmd = CMD_A; end
                ASCII_S: begin cls = CLS_CMD; cmd = CMD_S; end
                ASCII_T: begin cls = CLS_CMD; cmd = CMD_T; end
                ASCII_E: cls = CLS_TERM;
                ASCII_CR, ASCII_LF: begin
                    if (term_on_nl) cls = CLS_TERM;
                end
                ASCII_SP: cls = CLS_SPACE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses <letter><hex digits><terminator> commands from a UART byte stream
// and presents each completed command on a valid/ack word channel.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int MAX_DIG     = 8,
    parameter int TIMEOUT_CYC = 0,
    parameter int TERM_ON_NL  = 1
) (
    input  logic               i_clk,
    input  logic               rst,
    input  logic               i_stb,
    input  logic [7:0]         i_data,
    uart_cmd_parser_if.master  bus,
    output logic               o_err_char,
    output logic               o_err_tmo,
    output logic               o_err_drop,
    output logic               o_busy
);

    localparam int DATA_W = 4 * MAX_DIG;
    localparam int NDIG_W = $clog2(MAX_DIG + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 2);

    chr_class_e        cls;
    logic [3:0]        nibble;
    logic [2:0]        chr_cmd;
    logic              unused_msb;

    state_e            state_q, state_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] arg_q, arg_d;
    logic [NDIG_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [TMO_W-1:0]  idle_q, idle_d;
    logic              emit;
    logic              err_char_d, err_tmo_d;

    logic              stb_q;
    logic [2:0]        ocmd_q;
    logic [DATA_W-1:0] oarg_q;
    logic [NDIG_W-1:0] ondig_q;
    logic              oovf_q;
    logic              err_char_q, err_tmo_q, err_drop_q;

    assign unused_msb = i_data[7];

    uart_ascii_classify u_classify (
        .chr        (i_data[6:0]),
        .term_on_nl (TERM_ON_NL != 0),
        .cls        (cls),
        .nibble     (nibble),
        .cmd        (chr_cmd)
    );

    // Next-state and word accumulation; a received byte always takes priority over the timeout.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        idle_d     = idle_q;
        emit       = 1'b0;
        err_char_d = 1'b0;
        err_tmo_d  = 1'b0;
        if (i_stb) begin
            idle_d = '0;
            case (state_q)
                IDLE: begin
                    case (cls)
                        CLS_CMD: begin
                            cmd_d   = chr_cmd;
                            arg_d   = '0;
                            cnt_d   = '0;
                            ovf_d   = 1'b0;
                            state_d = ACCUM;
                        end
                        CLS_DIGIT, CLS_OTHER: err_char_d = 1'b1;
                        default: ;
                    endcase
                end
                ACCUM: begin
                    case (cls)
                        CLS_DIGIT: begin
                            if (cnt_q < NDIG_W'(MAX_DIG)) begin
                                arg_d = (arg_q << 4) | DATA_W'(nibble);
                                cnt_d = cnt_q + NDIG_W'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                        CLS_TERM: begin
                            emit    = 1'b1;
                            state_d = IDLE;
                        end
                        // A new command letter closes the current word and opens the next one.
                        CLS_CMD: begin
                            emit  = 1'b1;
                            cmd_d = chr_cmd;
                            arg_d = '0;
                            cnt_d = '0;
                            ovf_d = 1'b0;
                        end
                        CLS_OTHER: begin
                            err_char_d = 1'b1;
                            state_d    = IDLE;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end else if (TIMEOUT_CYC > 0 && state_q == ACCUM) begin
            idle_d = idle_q + TMO_W'(1);
            if (idle_d == TMO_W'(TIMEOUT_CYC)) begin
                err_tmo_d = 1'b1;
                idle_d    = '0;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            arg_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            idle_q  <= idle_d;
        end
    end

    // Output word register: a new word only replaces a held one when it is acked in the same cycle.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            stb_q      <= 1'b0;
            ocmd_q     <= '0;
            oarg_q     <= '0;
            ondig_q    <= '0;
            oovf_q     <= 1'b0;
            err_char_q <= 1'b0;
            err_tmo_q  <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            err_char_q <= err_char_d;
            err_tmo_q  <= err_tmo_d;
            err_drop_q <= 1'b0;
            if (emit) begin
                if (!stb_q || bus.i_ack) begin
                    stb_q   <= 1'b1;
                    ocmd_q  <= cmd_q;
                    oarg_q  <= arg_q;
                    ondig_q <= cnt_q;
                    oovf_q  <= ovf_q;
                end else begin
                    err_drop_q <= 1'b1;
                end
            end else if (stb_q && bus.i_ack) begin
                stb_q <= 1'b0;
            end
        end
    end

    assign bus.o_stb  = stb_q;
    assign bus.o_cmd  = ocmd_q;
    assign bus.o_arg  = oarg_q;
    assign bus.o_ndig = ondig_q;
    assign bus.o_ovf  = oovf_q;
    assign o_err_char = err_char_q;
    assign o_err_tmo  = err_tmo_q;
    assign o_err_drop = err_drop_q;
    assign o_busy     = (state_q == ACCUM);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a vector table for byte streams plus
// hand-written timeout and reset sequences.
module tb_uart_cmd_parser;

    logic       i_clk = 1'b0;
    logic       rst;
    logic       i_stb;
    logic [7:0] i_data;
    logic       o_err_char, o_err_tmo, o_err_drop, o_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        stb;
        logic [7:0]  data;
        logic        ack;
        logic        e_stb;
        logic [2:0]  e_cmd;
        logic [31:0] e_arg;
        int          e_ndig;
        logic        e_ovf;
        logic [2:0]  e_err;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    always #5 i_clk = ~i_clk;

    uart_cmd_parser_if #(.MAX_DIG(8)) bus ();

    uart_cmd_parser #(
        .MAX_DIG     (8),
        .TIMEOUT_CYC (16),
        .TERM_ON_NL  (1)
    ) dut (
        .i_clk      (i_clk),
        .rst        (rst),
        .i_stb      (i_stb),
        .i_data     (i_data),
        .bus        (bus),
        .o_err_char (o_err_char),
        .o_err_tmo  (o_err_tmo),
        .o_err_drop (o_err_drop),
        .o_busy     (o_busy)
    );

    task automatic add(input logic s, input logic [7:0] d, input logic a,
                       input logic es, input logic [2:0] ec, input logic [31:0] ea,
                       input int en, input logic eo, input logic [2:0] eerr, input logic eb);
        vec_t v;
        v.stb = s; v.data = d; v.ack = a;
        v.e_stb = es; v.e_cmd = ec; v.e_arg = ea; v.e_ndig = en;
        v.e_ovf = eo; v.e_err = eerr; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    // One clock: inputs are driven before the edge, outputs read 1 time unit after it.
    task automatic applyStimulus(input logic s, input logic [7:0] d, input logic a);
        i_stb     = s;
        i_data    = d;
        bus.i_ack = a;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Control bits are {o_stb, err_char, err_tmo, err_drop, busy}; the word is only checked while valid.
    task automatic checkOutput(input string nm, input logic es, input logic [2:0] ec,
                               input logic [31:0] ea, input int en, input logic eo,
                               input logic [2:0] eerr, input logic eb);
        chk({nm, " ctl"}, 64'({bus.o_stb, o_err_char, o_err_tmo, o_err_drop, o_busy}),
            64'({es, eerr, eb}));
        if (es)
            chk({nm, " word"}, 64'({bus.o_cmd, bus.o_arg, bus.o_ndig, bus.o_ovf}),
                64'({ec, ea, 4'(en), eo}));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; i_stb = 1'b0; i_data = 8'h00; bus.i_ack = 1'b0;
        applyStimulus(0, 8'h00, 0);
        applyStimulus(0, 8'h00, 0);
        chk("reset ctl", 64'({bus.o_stb, o_err_char, o_err_tmo, o_err_drop, o_busy}), 64'd0);
        chk("reset word", 64'({bus.o_cmd, bus.o_arg, bus.o_ndig, bus.o_ovf}), 64'd0);
        rst = 1'b0;

        // "A20W1E" with ack held high
        add(1, "A", 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, "2", 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, "0", 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, "W", 1, 1, 3'd2, 32'h20, 2, 0, 3'b000, 1);
        add(1, "1", 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, "E", 1, 1, 3'd1, 32'h1, 1, 0, 3'b000, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 3'b000, 0);
        // "R123456789E": ninth digit overflows
        add(1, "R", 1, 0, 0, 0, 0, 0, 3'b000, 1);
        for (int i = 1; i <= 9; i++)
            add(1, 8'(8'h30 + i), 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, "E", 1, 1, 3'd0, 32'h12345678, 8, 1, 3'b000, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 3'b000, 0);
        // "Wxz" then "R5E"
        add(1, "W", 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, "x", 1, 0, 0, 0, 0, 0, 3'b100, 0);
        add(1, "z", 1, 0, 0, 0, 0, 0, 3'b100, 0);
        add(1, "R", 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, "5", 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, "E", 1, 1, 3'd0, 32'h5, 1, 0, 3'b000, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 3'b000, 0);
        // Idle terminators/space ignored, upper-case non-command rejected, bit 7 ignored, CR/LF terminate
        add(1, "E", 1, 0, 0, 0, 0, 0, 3'b000, 0);
        add(1, " ", 1, 0, 0, 0, 0, 0, 3'b000, 0);
        add(1, "B", 1, 0, 0, 0, 0, 0, 3'b100, 0);
        add(1, 8'hD4, 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, " ", 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, "3", 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, "f", 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, 8'h0D, 1, 1, 3'd6, 32'h3f, 2, 0, 3'b000, 0);
        add(1, "S", 1, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, 8'h0A, 1, 1, 3'd3, 32'h0, 0, 0, 3'b000, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 3'b000, 0);
        // "R1ER2E" with ack low: second word dropped, first held until acked
        add(1, "R", 0, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, "1", 0, 0, 0, 0, 0, 0, 3'b000, 1);
        add(1, "E", 0, 1, 3'd0, 32'h1, 1, 0, 3'b000, 0);
        add(1, "R", 0, 1, 3'd0, 32'h1, 1, 0, 3'b000, 1);
        add(1, "2", 0, 1, 3'd0, 32'h1, 1, 0, 3'b000, 1);
        add(1, "E", 0, 1, 3'd0, 32'h1, 1, 0, 3'b001, 0);
        add(0, 8'h00, 0, 1, 3'd0, 32'h1, 1, 0, 3'b000, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 3'b000, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].stb, vecs[i].data, vecs[i].ack);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_stb, vecs[i].e_cmd, vecs[i].e_arg,
                        vecs[i].e_ndig, vecs[i].e_ovf, vecs[i].e_err, vecs[i].e_busy);
        end

        // Timeout: "W3" then silence fires on the 16th idle cycle
        applyStimulus(1, "W", 1);
        applyStimulus(1, "3", 1);
        for (int k = 1; k <= 15; k++) applyStimulus(0, 8'h00, 1);
        checkOutput("tmo idle15", 0, 0, 0, 0, 0, 3'b000, 1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("tmo fire", 0, 0, 0, 0, 0, 3'b010, 0);
        applyStimulus(0, 8'h00, 1);
        checkOutput("tmo after", 0, 0, 0, 0, 0, 3'b000, 0);

        // A byte landing exactly on idle cycle 16 keeps the word alive
        applyStimulus(1, "W", 1);
        applyStimulus(1, "3", 1);
        for (int k = 1; k <= 15; k++) applyStimulus(0, 8'h00, 1);
        applyStimulus(1, "4", 1);
        checkOutput("tmo saved", 0, 0, 0, 0, 0, 3'b000, 1);
        for (int k = 1; k <= 15; k++) applyStimulus(0, 8'h00, 1);
        checkOutput("tmo restart", 0, 0, 0, 0, 0, 3'b000, 1);
        applyStimulus(1, "E", 1);
        checkOutput("tmo word", 1, 3'd1, 32'h34, 2, 0, 3'b000, 0);
        applyStimulus(0, 8'h00, 1);

        // Reset mid-word with a held output word, then "S7\n"
        applyStimulus(1, "R", 0);
        applyStimulus(1, "9", 0);
        applyStimulus(1, "E", 0);
        applyStimulus(1, "A", 0);
        applyStimulus(1, "1", 0);
        applyStimulus(1, "2", 0);
        checkOutput("pre-rst held", 1, 3'd0, 32'h9, 1, 0, 3'b000, 1);
        rst = 1'b1;
        applyStimulus(1, "E", 0);
        rst = 1'b0;
        chk("rst ctl", 64'({bus.o_stb, o_err_char, o_err_tmo, o_err_drop, o_busy}), 64'd0);
        chk("rst word", 64'({bus.o_cmd, bus.o_arg, bus.o_ndig, bus.o_ovf}), 64'd0);
        applyStimulus(1, "S", 1);
        checkOutput("post-rst S", 0, 0, 0, 0, 0, 3'b000, 1);
        applyStimulus(1, "7", 1);
        applyStimulus(1, 8'h0A, 1);
        checkOutput("post-rst word", 1, 3'd3, 32'h7, 1, 0, 3'b000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Parametrised successor to the UART ASCII hex decoder. It consumes the byte stream from the UART receiver and parses commands of the form <letter><hex digits><terminator>, e.g. "A20W1E". Each completed command is emitted as one word on a valid/ack handshake toward the bus master. Over the old decoder it adds configurable argument width, digit-overflow detection, an idle timeout, newline termination, error pulses and back-pressure with drop reporting.

Parameters:
MAX_DIG, 8, maximum hex digits per argument; DATA_W = 4*MAX_DIG
TIMEOUT_CYC, 0, idle cycles before a partial word is aborted; 0 disables the timeout
TERM_ON_NL, 1, when 1, CR (0x0D) and LF (0x0A) also terminate a word like 'E'

Ports:
i_clk  in  1  clock
rst  in  1  synchronous active-high reset
i_stb  in  1  one-cycle strobe: i_data holds a received byte
i_data  in  8  received byte; bit 7 ignored
o_stb  out  1  command word valid; held until acked
i_ack  in  1  downstream accepts the word in any cycle where o_stb=1
o_cmd  out  3  R=0, W=1, A=2, S=3, T=6
o_arg  out  DATA_W  hex argument, right-aligned (last digit in bits [3:0])
o_ndig  out  $clog2(MAX_DIG+1)  number of digits captured
o_ovf  out  1  word had more than MAX_DIG digits
o_err_char  out  1  one-cycle pulse: illegal character
o_err_tmo  out  1  one-cycle pulse: partial word aborted by timeout
o_err_drop  out  1  one-cycle pulse: completed word lost because output was still held
o_busy  out  1  parser is in ACCUM

Behaviour:
- Single clock i_clk. rst is synchronous and active-high. All outputs reset to 0; state resets to IDLE; accumulators clear. rst overrides everything, including mid-word and a pending o_stb.
- Input is never stalled. Every i_stb byte is classified in the same cycle as one of: DIGIT ('0'-'9', 'a'-'f'), CMD ('R','W','A','S','T'), TERM ('E', plus CR/LF when TERM_ON_NL=1), SPACE (0x20), OTHER.
- IDLE:
  - CMD: latch cmd; clear arg, count and ovf; go to ACCUM.
  - TERM or SPACE: ignored.
  - DIGIT or OTHER: o_err_char pulse; stay in IDLE.
- ACCUM:
  - DIGIT with count < MAX_DIG: arg <= {arg[DATA_W-5:0], digit}; count++.
  - DIGIT with count = MAX_DIG: digit discarded; ovf sticky set.
  - SPACE: ignored.
  - TERM: emit; go to IDLE.
  - CMD: emit the current word and, in the same cycle, start the new word (latch cmd, clear arg/count/ovf); stay in ACCUM.
  - OTHER: o_err_char pulse; word discarded with no emit; go to IDLE.
- A command with zero digits is legal: it is emitted with arg=0 and ndig=0.
- Timeout (TIMEOUT_CYC>0):
  - The idle counter clears on every i_stb and counts only in ACCUM.
  - When it reaches TIMEOUT_CYC: o_err_tmo pulse, word discarded, go to IDLE.
  - If i_stb arrives in the same cycle, the byte wins and no timeout occurs.
- Emit, with output register latency of 1 (o_stb rises the cycle after the terminating i_stb):
  - If o_stb=0, or o_stb=1 with i_ack=1 in that cycle: load o_cmd/o_arg/o_ndig/o_ovf and set o_stb=1.
  - Otherwise: o_err_drop pulse; the output holds its old word unchanged.
- i_ack with o_stb=1 and no emit: o_stb falls next cycle. i_ack while o_stb=0 is ignored.
- Error pulses are independent and may coincide with o_stb activity.

Decomposition:
- Package uart_cmd_pkg:
  - cmd_e enum (CMD_R=0, CMD_W=1, CMD_A=2, CMD_S=3, CMD_T=6)
  - chr_class_e enum (DIGIT, CMD, TERM, SPACE, OTHER)
  - ASCII constants
  - state_e (IDLE, ACCUM)
- Sub-module uart_ascii_classify: combinational. Takes 7-bit char and TERM_ON_NL; returns class, 4-bit nibble and 3-bit cmd code.

Test Plan:
- "A20W1E" with i_ack tied 1 -> words {A,0x20,ndig 2}, then {W,0x1,ndig 1}; each o_stb is 1 cycle, 1 cycle after the 'W' and 'E' strobes.
- MAX_DIG=8, "R123456789E" -> {R, arg 0x12345678, ndig 8, ovf 1}; no error pulses.
- "Wxz" then "R5E" -> o_err_char on 'x' (word discarded); 'z' in IDLE -> second o_err_char; then {R,0x5}.
- i_ack held 0, "R1ER2E" -> first word {R,0x1} held; o_err_drop pulse one cycle after 'E' #2; i_ack then clears o_stb.
- TIMEOUT_CYC=16, "W3" then silence -> o_err_tmo on idle cycle 16, o_busy falls, no word; a byte arriving on cycle 16 exactly prevents the timeout.
- rst asserted mid "A12" -> all outputs 0 next cycle; following "S7\n" (TERM_ON_NL=1) -> {S,0x7}.
